// File: rtl/wb_slave_mux_if.sv
// rtl/wb_slave_mux_if.sv - Wishbone master-side and slave-fanout bundle for wb_slave_mux
interface wb_slave_mux_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]              m_data_i;
    logic [31:0]              m_addr_i;
    logic                     m_cyc_i;
    logic                     m_strobe_i;
    logic                     m_we_i;
    logic [31:0]              m_data_o;
    logic                     m_ack_o;
    logic                     m_err_o;
    logic [31:0]              s_data_o;
    logic [31:0]              s_addr_o;
    logic                     s_we_o;
    logic [NUM_SLAVES-1:0]    s_cyc_o;
    logic [NUM_SLAVES-1:0]    s_strobe_o;
    logic [NUM_SLAVES*32-1:0] s_data_i;
    logic [NUM_SLAVES-1:0]    s_ack_i;

    // The mux itself is the Wishbone slave of the external master.
    modport slave (
        input  m_data_i, m_addr_i, m_cyc_i, m_strobe_i, m_we_i, s_data_i, s_ack_i,
        output m_data_o, m_ack_o, m_err_o, s_data_o, s_addr_o, s_we_o, s_cyc_o, s_strobe_o
    );

    modport master (
        output m_data_i, m_addr_i, m_cyc_i, m_strobe_i, m_we_i, s_data_i, s_ack_i,
        input  m_data_o, m_ack_o, m_err_o, s_data_o, s_addr_o, s_we_o, s_cyc_o, s_strobe_o
    );
endinterface

// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - Wishbone backdoor interconnect: address-field slave select, registered
// request/ack, error response for unmapped slots and ack timeouts.
module wb_slave_mux #(
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 16,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clock,
    input  logic            reset,
    wb_slave_mux_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [SEL_BITS-1:0]   slot;
    logic [NUM_SLAVES-1:0] slot_onehot;
    logic                  slot_mapped;
    logic                  slave_ack;
    logic [31:0]           slave_rdata;

    // The registered strobe is the one-hot of the active slot, so it doubles as the
    // ack/data select and stray acks from other slaves or outside ACTIVE fall away.
    always_comb begin
        slot        = bus.m_addr_i[SEL_LSB +: SEL_BITS];
        slot_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (slot == k[SEL_BITS-1:0]) slot_onehot[k] = 1'b1;
        end
        slot_mapped = |slot_onehot;
        slave_ack   = |(bus.s_ack_i & bus.s_strobe_o);
        slave_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (bus.s_strobe_o[k]) slave_rdata = slave_rdata | bus.s_data_i[32*k +: 32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            bus.m_data_o   <= '0;
            bus.m_ack_o    <= 1'b0;
            bus.m_err_o    <= 1'b0;
            bus.s_data_o   <= '0;
            bus.s_addr_o   <= '0;
            bus.s_we_o     <= 1'b0;
            bus.s_cyc_o    <= '0;
            bus.s_strobe_o <= '0;
        end else begin
            bus.m_ack_o <= 1'b0;
            bus.m_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_cyc_i && bus.m_strobe_i) begin
                        bus.s_addr_o <= bus.m_addr_i;
                        bus.s_data_o <= bus.m_data_i;
                        bus.s_we_o   <= bus.m_we_i;
                        count        <= '0;
                        if (slot_mapped) begin
                            state          <= ACTIVE;
                            bus.s_cyc_o    <= slot_onehot;
                            bus.s_strobe_o <= slot_onehot;
                        end else begin
                            state        <= ERR;
                            bus.m_err_o  <= 1'b1;
                            bus.m_data_o <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    // Abort outranks a same-cycle ack: the master has already walked away.
                    if (!bus.m_cyc_i) begin
                        state          <= IDLE;
                        bus.s_cyc_o    <= '0;
                        bus.s_strobe_o <= '0;
                    end else if (slave_ack) begin
                        state          <= RESP;
                        bus.m_ack_o    <= 1'b1;
                        bus.m_data_o   <= slave_rdata;
                        bus.s_cyc_o    <= '0;
                        bus.s_strobe_o <= '0;
                    end else if (count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state          <= ERR;
                        bus.m_err_o    <= 1'b1;
                        bus.m_data_o   <= '0;
                        bus.s_cyc_o    <= '0;
                        bus.s_strobe_o <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - self-checking bench for wb_slave_mux (4-slave and 3-slave instances)
module tb_wb_slave_mux;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    wb_slave_mux_if #(.NUM_SLAVES(4)) bus4 ();
    wb_slave_mux_if #(.NUM_SLAVES(3)) bus3 ();

    wb_slave_mux #(.NUM_SLAVES(4), .SEL_LSB(16), .SEL_BITS(2), .TIMEOUT_CYCLES(16)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4));
    wb_slave_mux #(.NUM_SLAVES(3), .SEL_LSB(16), .SEL_BITS(2), .TIMEOUT_CYCLES(16)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3));

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   ack_cnt;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, bus4.s_addr_o, bus4.s_data_o, bus4.s_we_o, bus4.s_cyc_o, bus4.s_strobe_o} !== '0) $display("FAIL reset4_outputs: got ack=%b err=%b data=%h addr=%h strobe=%b want all zero", bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, bus4.s_addr_o, bus4.s_strobe_o); else n_pass++;
        n_total++; if ({bus3.m_ack_o, bus3.m_err_o, bus3.m_data_o, bus3.s_addr_o, bus3.s_data_o, bus3.s_we_o, bus3.s_cyc_o, bus3.s_strobe_o} !== '0) $display("FAIL reset3_outputs: got ack=%b err=%b data=%h strobe=%b want all zero", bus3.m_ack_o, bus3.m_err_o, bus3.m_data_o, bus3.s_strobe_o); else n_pass++;
        reset = 1'b0;
        step();
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o} !== 6'b0) $display("FAIL reset_idle: got ack=%b err=%b strobe=%b want 0 0 0000", bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o); else n_pass++;
        step();
    endtask

    task automatic test_read_immediate();
        bus4.m_addr_i = 32'h0001_0004; bus4.m_we_i = 1'b0; bus4.m_cyc_i = 1'b1; bus4.m_strobe_i = 1'b1;
        sb.push_back({1'b0, 32'h1234_5678});
        step();
        @(negedge clock);
        n_total++; if ({bus4.s_cyc_o, bus4.s_strobe_o} !== 8'b0010_0010) $display("FAIL rd_strobe: got cyc=%b strobe=%b want 0010 0010", bus4.s_cyc_o, bus4.s_strobe_o); else n_pass++;
        n_total++; if (bus4.s_addr_o !== 32'h0001_0004) $display("FAIL rd_addr: got %h want 00010004", bus4.s_addr_o); else n_pass++;
        n_total++; if (bus4.m_ack_o !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", bus4.m_ack_o); else n_pass++;
        bus4.s_ack_i = 4'b0010; bus4.s_data_i[32 +: 32] = 32'h1234_5678;
        step();
        bus4.s_ack_i = '0; bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0;
        @(negedge clock);
        n_total++;
        if (sb.size() == 0) $display("FAIL rd_resp: got response, want none queued");
        else begin
            e = sb.pop_front();
            if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o} !== {!e.err, e.err, e.data}) $display("FAIL rd_resp: got ack=%b err=%b data=%h want ack=%b err=%b data=%h", bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, !e.err, e.err, e.data); else n_pass++;
        end
        n_total++; if (bus4.s_strobe_o !== 4'b0) $display("FAIL rd_strobe_drop: got %b want 0000", bus4.s_strobe_o); else n_pass++;
        step();
        @(negedge clock);
        n_total++; if (bus4.m_ack_o !== 1'b0) $display("FAIL rd_ack_once: got %b want 0", bus4.m_ack_o); else n_pass++;
        step();
    endtask

    task automatic test_write_late_ack();
        bus4.m_addr_i = 32'h0000_0010; bus4.m_data_i = 32'hCAFE_0001; bus4.m_we_i = 1'b1;
        bus4.m_cyc_i = 1'b1; bus4.m_strobe_i = 1'b1;
        bus4.s_data_i[0 +: 32] = 32'h0BAD_F00D;
        sb.push_back({1'b0, 32'h0BAD_F00D});
        step();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o} !== 6'b00_0001) $display("FAIL wr_wait_c%0d: got ack=%b err=%b strobe=%b want 0 0 0001", c, bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o); else n_pass++;
            if (c == 1) begin
                n_total++; if ({bus4.s_we_o, bus4.s_data_o, bus4.s_addr_o} !== {1'b1, 32'hCAFE_0001, 32'h0000_0010}) $display("FAIL wr_latch: got we=%b data=%h addr=%h want 1 cafe0001 00000010", bus4.s_we_o, bus4.s_data_o, bus4.s_addr_o); else n_pass++;
            end
            if (c == 3) bus4.s_ack_i = 4'b0001;
            step();
        end
        bus4.s_ack_i = '0; bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0; bus4.m_we_i = 1'b0;
        @(negedge clock);
        n_total++;
        if (sb.size() == 0) $display("FAIL wr_resp: got response, want none queued");
        else begin
            e = sb.pop_front();
            if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o} !== {!e.err, e.err, e.data}) $display("FAIL wr_resp: got ack=%b err=%b data=%h want ack=%b err=%b data=%h", bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, !e.err, e.err, e.data); else n_pass++;
        end
        step();
    endtask

    task automatic test_unmapped();
        bus3.m_addr_i = 32'h0000_0000; bus3.m_we_i = 1'b0; bus3.m_cyc_i = 1'b1; bus3.m_strobe_i = 1'b1;
        bus3.s_data_i[0 +: 32] = 32'h55AA_55AA;
        sb.push_back({1'b0, 32'h55AA_55AA});
        step();
        @(negedge clock);
        bus3.s_ack_i = 3'b001;
        step();
        bus3.s_ack_i = '0; bus3.m_cyc_i = 1'b0; bus3.m_strobe_i = 1'b0;
        @(negedge clock);
        n_total++;
        if (sb.size() == 0) $display("FAIL um_preload: got response, want none queued");
        else begin
            e = sb.pop_front();
            if ({bus3.m_ack_o, bus3.m_err_o, bus3.m_data_o} !== {!e.err, e.err, e.data}) $display("FAIL um_preload: got ack=%b err=%b data=%h want ack=%b err=%b data=%h", bus3.m_ack_o, bus3.m_err_o, bus3.m_data_o, !e.err, e.err, e.data); else n_pass++;
        end
        step();
        bus3.m_addr_i = 32'h0003_0000; bus3.m_cyc_i = 1'b1; bus3.m_strobe_i = 1'b1;
        sb.push_back({1'b1, 32'h0});
        step();
        @(negedge clock);
        n_total++;
        if (sb.size() == 0) $display("FAIL um_resp: got response, want none queued");
        else begin
            e = sb.pop_front();
            if ({bus3.m_ack_o, bus3.m_err_o, bus3.m_data_o} !== {!e.err, e.err, e.data}) $display("FAIL um_resp: got ack=%b err=%b data=%h want ack=%b err=%b data=%h", bus3.m_ack_o, bus3.m_err_o, bus3.m_data_o, !e.err, e.err, e.data); else n_pass++;
        end
        n_total++; if ({bus3.s_cyc_o, bus3.s_strobe_o} !== 6'b0) $display("FAIL um_strobe: got cyc=%b strobe=%b want 000 000", bus3.s_cyc_o, bus3.s_strobe_o); else n_pass++;
        bus3.m_cyc_i = 1'b0; bus3.m_strobe_i = 1'b0;
        step();
        @(negedge clock);
        n_total++; if (bus3.m_err_o !== 1'b0) $display("FAIL um_err_once: got %b want 0", bus3.m_err_o); else n_pass++;
        step();
    endtask

    task automatic test_timeout();
        bus4.m_addr_i = 32'h0002_0000; bus4.m_we_i = 1'b0; bus4.m_cyc_i = 1'b1; bus4.m_strobe_i = 1'b1;
        sb.push_back({1'b1, 32'h0});
        step();
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o} !== 6'b00_0100) $display("FAIL to_wait_c%0d: got ack=%b err=%b strobe=%b want 0 0 0100", c, bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o); else n_pass++;
            step();
        end
        bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0;
        @(negedge clock);
        n_total++;
        if (sb.size() == 0) $display("FAIL to_resp: got response, want none queued");
        else begin
            e = sb.pop_front();
            if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o} !== {!e.err, e.err, e.data}) $display("FAIL to_resp: got ack=%b err=%b data=%h want ack=%b err=%b data=%h", bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, !e.err, e.err, e.data); else n_pass++;
        end
        n_total++; if (bus4.s_strobe_o !== 4'b0) $display("FAIL to_strobe_drop: got %b want 0000", bus4.s_strobe_o); else n_pass++;
        step();
        @(negedge clock);
        n_total++; if ({bus4.m_err_o, bus4.s_strobe_o} !== 5'b0) $display("FAIL to_idle: got err=%b strobe=%b want 0 0000", bus4.m_err_o, bus4.s_strobe_o); else n_pass++;
        step();
    endtask

    task automatic test_stray_abort();
        bus4.m_addr_i = 32'h0001_0000; bus4.m_we_i = 1'b0; bus4.m_cyc_i = 1'b1; bus4.m_strobe_i = 1'b1;
        bus4.s_data_i[32 +: 32] = 32'hDEAD_0001;
        step();
        @(negedge clock);
        n_total++; if (bus4.s_strobe_o !== 4'b0010) $display("FAIL sa_strobe: got %b want 0010", bus4.s_strobe_o); else n_pass++;
        bus4.s_ack_i = 4'b0001;
        step();
        bus4.s_ack_i = 4'b0010; bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0;
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o} !== 6'b00_0010) $display("FAIL sa_stray_ignored: got ack=%b err=%b strobe=%b want 0 0 0010", bus4.m_ack_o, bus4.m_err_o, bus4.s_strobe_o); else n_pass++;
        step();
        bus4.s_ack_i = '0;
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.s_cyc_o, bus4.s_strobe_o} !== 10'b0) $display("FAIL sa_abort: got ack=%b err=%b cyc=%b strobe=%b want all 0", bus4.m_ack_o, bus4.m_err_o, bus4.s_cyc_o, bus4.s_strobe_o); else n_pass++;
        step();
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o} !== 34'b0) $display("FAIL sa_no_resp: got ack=%b err=%b data=%h want 0 0 00000000", bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL sa_sb_empty: got %0d pending want 0", sb.size()); else n_pass++;
        step();
    endtask

    task automatic test_reset_midflight();
        bus4.m_addr_i = 32'h0003_0000; bus4.m_we_i = 1'b0; bus4.m_cyc_i = 1'b1; bus4.m_strobe_i = 1'b1;
        bus4.s_data_i[96 +: 32] = 32'h7777_7777;
        step();
        @(negedge clock);
        n_total++; if (bus4.s_strobe_o !== 4'b1000) $display("FAIL rm_strobe: got %b want 1000", bus4.s_strobe_o); else n_pass++;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0; bus4.s_ack_i = 4'b1000;
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, bus4.s_addr_o, bus4.s_we_o, bus4.s_cyc_o, bus4.s_strobe_o} !== '0) $display("FAIL rm_cleared: got ack=%b err=%b addr=%h cyc=%b strobe=%b want all 0", bus4.m_ack_o, bus4.m_err_o, bus4.s_addr_o, bus4.s_cyc_o, bus4.s_strobe_o); else n_pass++;
        step();
        bus4.s_ack_i = '0;
        @(negedge clock);
        n_total++; if ({bus4.m_ack_o, bus4.m_err_o} !== 2'b00) $display("FAIL rm_late_ack: got ack=%b err=%b want 0 0", bus4.m_ack_o, bus4.m_err_o); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        ack_cnt = 0;
        bus4.m_addr_i = 32'h0000_0020; bus4.m_we_i = 1'b0; bus4.m_cyc_i = 1'b1; bus4.m_strobe_i = 1'b1;
        bus4.s_data_i[0 +: 32] = 32'hA0A0_0000; bus4.s_data_i[96 +: 32] = 32'h3333_CCCC;
        sb.push_back({1'b0, 32'hA0A0_0000});
        sb.push_back({1'b0, 32'h3333_CCCC});
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 2) bus4.s_ack_i = '0;
            if (c == 2) bus4.m_addr_i = 32'h0003_0024;
            if (c == 5) begin bus4.s_ack_i = '0; bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0; end
            @(negedge clock);
            if (bus4.m_ack_o === 1'b1) ack_cnt++;
            if (c == 1 || c == 4) begin
                n_total++; if (bus4.s_strobe_o !== ((c == 1) ? 4'b0001 : 4'b1000)) $display("FAIL b2b_strobe_c%0d: got %b want %b", c, bus4.s_strobe_o, (c == 1) ? 4'b0001 : 4'b1000); else n_pass++;
                bus4.s_ack_i = bus4.s_strobe_o;
            end
            if (c == 2 || c == 5) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL b2b_resp_c%0d: got response, want none queued", c);
                else begin
                    e = sb.pop_front();
                    if ({bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o} !== {!e.err, e.err, e.data}) $display("FAIL b2b_resp_c%0d: got ack=%b err=%b data=%h want ack=%b err=%b data=%h", c, bus4.m_ack_o, bus4.m_err_o, bus4.m_data_o, !e.err, e.err, e.data); else n_pass++;
                end
            end
            if (c == 4) begin
                n_total++; if (bus4.s_addr_o !== 32'h0003_0024) $display("FAIL b2b_addr: got %h want 00030024", bus4.s_addr_o); else n_pass++;
            end
        end
        n_total++; if (ack_cnt !== 2) $display("FAIL b2b_ack_count: got %0d want 2", ack_cnt); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL b2b_sb_empty: got %0d pending want 0", sb.size()); else n_pass++;
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus4.m_data_i = '0; bus4.m_addr_i = '0; bus4.m_cyc_i = 1'b0; bus4.m_strobe_i = 1'b0;
        bus4.m_we_i = 1'b0; bus4.s_data_i = '0; bus4.s_ack_i = '0;
        bus3.m_data_i = '0; bus3.m_addr_i = '0; bus3.m_cyc_i = 1'b0; bus3.m_strobe_i = 1'b0;
        bus3.m_we_i = 1'b0; bus3.s_data_i = '0; bus3.s_ack_i = '0;
        test_reset();
        test_read_immediate();
        test_write_late_ack();
        test_unmapped();
        test_timeout();
        test_stray_abort();
        test_reset_midflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
